// File: rtl/mul_seq.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU); optional zero-operand bypass under MUL_ZERO_BYPASS_EN.
// Latency: done 35 cycles after the accepting start (1 cycle when bypassed); start is ignored while busy.

// 32-bit ripple-style adder shared by accumulation and sign fix-up.
// Latency: combinational.
// Backpressure: none.
module adder (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {32'b0, cin};
endmodule

// Shift-add multiplier: one partial product per cycle, then two negation passes.
// Latency: start in cycle 0, busy cycles 1-34, done pulse cycle 35.
// Backpressure: start is only accepted in IDLE or DONE; otherwise dropped.
module mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, CALC, NEG_LO, NEG_HI, DONE} state_t;

    state_t      state;
    logic        c;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ma;
    logic [4:0]  cnt;
    logic        neg;
    logic        is_mul;

    logic        accept;
    logic        sa;
    logic        sb;
    logic [31:0] ma_in;
    logic [31:0] mb_in;

    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    assign accept = start && (state == IDLE || state == DONE);
    assign sa     = a[31] && (funct == 2'b01 || funct == 2'b10);
    assign sb     = b[31] && (funct == 2'b01);
    assign ma_in  = sa ? (~a + 32'd1) : a;
    assign mb_in  = sb ? (~b + 32'd1) : b;

    // Single adder; operands steered by state.
    always_comb begin
        add_x   = hi;
        add_y   = 32'd0;
        add_cin = 1'b0;
        case (state)
            CALC: begin
                add_x = hi;
                add_y = lo[0] ? ma : 32'd0;
            end
            NEG_LO: begin
                add_x   = lo ^ {32{neg}};
                add_cin = neg;
            end
            NEG_HI: begin
                add_x   = hi ^ {32{neg}};
                add_cin = neg & c;
            end
            default: ;
        endcase
    end

    adder u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            c      <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            ma     <= 32'd0;
            cnt    <= 5'd0;
            neg    <= 1'b0;
            is_mul <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else if (accept) begin
            c      <= 1'b0;
            hi     <= 32'd0;
            lo     <= mb_in;
            ma     <= ma_in;
            cnt    <= 5'd0;
            neg    <= sa ^ sb;
            is_mul <= (funct == 2'b00);
`ifdef MUL_ZERO_BYPASS_EN
            if (a == 32'd0 || b == 32'd0) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= 32'd0;
            end else begin
                state <= CALC;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
            done  <= 1'b0;
`endif
        end else begin
            case (state)
                CALC: begin
                    c   <= 1'b0;
                    hi  <= {add_cout, add_sum[31:1]};
                    lo  <= {add_sum[0], lo[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= NEG_LO;
                end
                NEG_LO: begin
                    lo    <= add_sum;
                    c     <= add_cout;
                    state <= NEG_HI;
                end
                NEG_HI: begin
                    hi     <= add_sum;
                    result <= is_mul ? lo : add_sum;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
